// File: rtl/id_stage_p.sv
// id_stage_p: instruction-decode stage for the 5-stage pipeline.
// Decodes one instruction per cycle, reads the register file, detects
// load-use hazards and registers the result into the ID/EX register.
// Optional macro ID_BYPASS_EN: write-through from WB to the ID read ports.
module id_stage_p #(
  parameter int D_SIZE   = 32,
  parameter int NUM_REGS = 32,
  localparam int ADDR_W  = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_valid,
  input  logic [31:0]       inst,
  input  logic [31:0]       pc_in,
  input  logic [31:0]       pc4_in,
  output logic              id_ready,
  input  logic              wb_we,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [D_SIZE-1:0] wb_data,
  input  logic              ex_stall,
  input  logic              flush,
  output logic              ex_valid,
  output logic [5:0]        opcode_2_ex,
  output logic [31:0]       pc_2_ex,
  output logic [31:0]       pc4_2_ex,
  output logic [D_SIZE-1:0] rs_val_2_ex,
  output logic [D_SIZE-1:0] rt_val_2_ex,
  output logic [ADDR_W-1:0] rd_2_ex,
  output logic [D_SIZE-1:0] imm_2_ex,
  output logic              branch_2_ex,
  output logic              mem_read_2_ex,
  output logic              mem_to_reg_2_ex,
  output logic              mem_write_2_ex,
  output logic              halt_2_ex
);

  typedef enum logic {RUN, HALTED} state_t;

  state_t state_q, state_d;

  logic [D_SIZE-1:0] regs [NUM_REGS];

  logic [5:0]        op;
  logic [ADDR_W-1:0] rs_idx, rt_idx, rd_idx;
  logic [D_SIZE-1:0] imm_ext;
  logic [D_SIZE-1:0] rs_rd, rt_rd;

  logic              use_rs, use_rt;
  logic [ADDR_W-1:0] dec_dest;
  logic [D_SIZE-1:0] dec_imm;
  logic              dec_branch, dec_mem_read, dec_mem_to_reg, dec_mem_write, dec_halt;

  logic hz;
  logic accept;

  assign op      = inst[31:26];
  assign rs_idx  = inst[21 +: ADDR_W];
  assign rt_idx  = inst[16 +: ADDR_W];
  assign rd_idx  = inst[11 +: ADDR_W];
  assign imm_ext = {{(D_SIZE-16){inst[15]}}, inst[15:0]};

  // Register file read ports; r0 is hard-wired to zero.
  always_comb begin
    rs_rd = (rs_idx == '0) ? '0 : regs[rs_idx];
    rt_rd = (rt_idx == '0) ? '0 : regs[rt_idx];
`ifdef ID_BYPASS_EN
    if (wb_we && wb_addr != '0 && wb_addr == rs_idx) rs_rd = wb_data;
    if (wb_we && wb_addr != '0 && wb_addr == rt_idx) rt_rd = wb_data;
`endif
  end

  // Register file write port, cleared on reset; writes to r0 are dropped.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (wb_we && wb_addr != '0) begin
      regs[wb_addr] <= wb_data;
    end
  end

  // Opcode decode: which sources are read, destination, immediate, control.
  always_comb begin
    use_rs         = 1'b0;
    use_rt         = 1'b0;
    dec_dest       = '0;
    dec_imm        = '0;
    dec_branch     = 1'b0;
    dec_mem_read   = 1'b0;
    dec_mem_to_reg = 1'b0;
    dec_mem_write  = 1'b0;
    dec_halt       = 1'b0;
    if (op <= 6'd11) begin
      use_rs         = 1'b1;
      dec_mem_to_reg = 1'b1;
      if (!op[0]) begin
        use_rt   = 1'b1;
        dec_dest = rd_idx;
      end else begin
        dec_dest = rt_idx;
        dec_imm  = imm_ext;
      end
    end else begin
      case (op)
        6'd12: begin
          use_rs         = 1'b1;
          dec_dest       = rt_idx;
          dec_imm        = imm_ext;
          dec_mem_to_reg = 1'b1;
          dec_mem_read   = 1'b1;
        end
        6'd13: begin
          use_rs        = 1'b1;
          use_rt        = 1'b1;
          dec_imm       = imm_ext;
          dec_mem_write = 1'b1;
        end
        6'd14, 6'd16: begin
          use_rs     = 1'b1;
          dec_imm    = imm_ext;
          dec_branch = 1'b1;
        end
        6'd15: begin
          use_rs     = 1'b1;
          use_rt     = 1'b1;
          dec_imm    = imm_ext;
          dec_branch = 1'b1;
        end
        6'd17: dec_halt = 1'b1;
        default: ;
      endcase
    end
  end

  // Load-use hazard against the load currently in EX, and the accept handshake.
  always_comb begin
    hz = ex_valid && mem_read_2_ex && (rd_2_ex != '0) &&
         ((use_rs && rs_idx == rd_2_ex) || (use_rt && rt_idx == rd_2_ex));
    id_ready = reset && (state_q == RUN) && !ex_stall && !hz;
    accept   = if_valid && id_ready;
  end

  // HALT tracking: stop accepting after a HALT until the next flush.
  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (accept && dec_halt && !flush) state_d = HALTED;
      HALTED:  if (flush) state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= RUN;
    else        state_q <= state_d;
  end

  // ID/EX pipeline register: flush, then stall-hold, then load, else bubble.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset || flush || (!ex_stall && !accept)) begin
      if (!reset || flush || !ex_stall) begin
        ex_valid        <= 1'b0;
        opcode_2_ex     <= '0;
        pc_2_ex         <= '0;
        pc4_2_ex        <= '0;
        rs_val_2_ex     <= '0;
        rt_val_2_ex     <= '0;
        rd_2_ex         <= '0;
        imm_2_ex        <= '0;
        branch_2_ex     <= 1'b0;
        mem_read_2_ex   <= 1'b0;
        mem_to_reg_2_ex <= 1'b0;
        mem_write_2_ex  <= 1'b0;
        halt_2_ex       <= 1'b0;
      end
    end else if (!ex_stall) begin
      ex_valid        <= 1'b1;
      opcode_2_ex     <= op;
      pc_2_ex         <= pc_in;
      pc4_2_ex        <= pc4_in;
      rs_val_2_ex     <= use_rs ? rs_rd : '0;
      rt_val_2_ex     <= use_rt ? rt_rd : '0;
      rd_2_ex         <= dec_dest;
      imm_2_ex        <= dec_imm;
      branch_2_ex     <= dec_branch;
      mem_read_2_ex   <= dec_mem_read;
      mem_to_reg_2_ex <= dec_mem_to_reg;
      mem_write_2_ex  <= dec_mem_write;
      halt_2_ex       <= dec_halt;
    end
  end

endmodule

// File: tb/tb_id_stage_p.sv
// tb_id_stage_p: directed, table-driven bench for id_stage_p.
module tb_id_stage_p;

  localparam int D_SIZE = 32;
  localparam int ADDR_W = 5;

  logic              clk = 1'b0;
  logic              reset;
  logic              if_valid;
  logic [31:0]       inst, pc_in, pc4_in;
  logic              id_ready;
  logic              wb_we;
  logic [ADDR_W-1:0] wb_addr;
  logic [D_SIZE-1:0] wb_data;
  logic              ex_stall, flush;
  logic              ex_valid;
  logic [5:0]        opcode_2_ex;
  logic [31:0]       pc_2_ex, pc4_2_ex;
  logic [D_SIZE-1:0] rs_val_2_ex, rt_val_2_ex, imm_2_ex;
  logic [ADDR_W-1:0] rd_2_ex;
  logic              branch_2_ex, mem_read_2_ex, mem_to_reg_2_ex, mem_write_2_ex, halt_2_ex;

  int checks = 0;
  int errors = 0;

  id_stage_p #(.D_SIZE(D_SIZE), .NUM_REGS(32)) dut (
    .clk(clk), .reset(reset), .if_valid(if_valid), .inst(inst), .pc_in(pc_in),
    .pc4_in(pc4_in), .id_ready(id_ready), .wb_we(wb_we), .wb_addr(wb_addr),
    .wb_data(wb_data), .ex_stall(ex_stall), .flush(flush), .ex_valid(ex_valid),
    .opcode_2_ex(opcode_2_ex), .pc_2_ex(pc_2_ex), .pc4_2_ex(pc4_2_ex),
    .rs_val_2_ex(rs_val_2_ex), .rt_val_2_ex(rt_val_2_ex), .rd_2_ex(rd_2_ex),
    .imm_2_ex(imm_2_ex), .branch_2_ex(branch_2_ex), .mem_read_2_ex(mem_read_2_ex),
    .mem_to_reg_2_ex(mem_to_reg_2_ex), .mem_write_2_ex(mem_write_2_ex),
    .halt_2_ex(halt_2_ex)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] inst;
    logic [5:0]  op;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic [4:0]  ctrl;
  } vec_t;

  vec_t vecs [10];

  function automatic logic [31:0] encR(input logic [5:0] op, input logic [4:0] rs,
                                       input logic [4:0] rt, input logic [4:0] rd);
    return {op, rs, rt, rd, 11'd0};
  endfunction

  function automatic logic [31:0] encI(input logic [5:0] op, input logic [4:0] rs,
                                       input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [4:0] ctrlNow();
    return {branch_2_ex, mem_read_2_ex, mem_to_reg_2_ex, mem_write_2_ex, halt_2_ex};
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic valid, input logic [31:0] i, input logic [31:0] pc);
    if_valid = valid;
    inst     = i;
    pc_in    = pc;
    pc4_in   = pc + 32'd4;
  endtask

  task automatic wbWrite(input logic [4:0] addr, input logic [31:0] data);
    @(negedge clk);
    wb_we = 1'b1; wb_addr = addr; wb_data = data;
    @(negedge clk);
    wb_we = 1'b0;
  endtask

  initial begin
    // ctrl = {branch, mem_read, mem_to_reg, mem_write, halt}
    vecs[0] = '{encR(6'd0, 5'd1, 5'd2, 5'd6),          6'd0,  32'h11,   32'h22, 5'd6, 32'h0,        5'b00100};
    vecs[1] = '{encI(6'd1, 5'd3, 5'd4, 16'hFFFF),      6'd1,  32'h1234, 32'h0,  5'd4, 32'hFFFF_FFFF, 5'b00100};
    vecs[2] = '{encI(6'd12, 5'd1, 5'd5, 16'h0008),     6'd12, 32'h11,   32'h0,  5'd5, 32'h8,        5'b01100};
    vecs[3] = '{encI(6'd13, 5'd1, 5'd2, 16'h7FFF),     6'd13, 32'h11,   32'h22, 5'd0, 32'h7FFF,     5'b00010};
    vecs[4] = '{encI(6'd15, 5'd1, 5'd2, 16'h8000),     6'd15, 32'h11,   32'h22, 5'd0, 32'hFFFF_8000, 5'b10000};
    vecs[5] = '{encI(6'd14, 5'd3, 5'd2, 16'h0004),     6'd14, 32'h1234, 32'h0,  5'd0, 32'h4,        5'b10000};
    vecs[6] = '{encI(6'd16, 5'd2, 5'd0, 16'h0000),     6'd16, 32'h22,   32'h0,  5'd0, 32'h0,        5'b10000};
    vecs[7] = '{{6'd20, 26'd0},                        6'd20, 32'h0,    32'h0,  5'd0, 32'h0,        5'b00000};
    vecs[8] = '{encR(6'd10, 5'd2, 5'd3, 5'd9),         6'd10, 32'h22,   32'h1234, 5'd9, 32'h0,      5'b00100};
    vecs[9] = '{encR(6'd0, 5'd0, 5'd1, 5'd10),         6'd0,  32'h0,    32'h11, 5'd10, 32'h0,       5'b00100};

    reset = 1'b0; ex_stall = 1'b0; flush = 1'b0;
    wb_we = 1'b0; wb_addr = '0; wb_data = '0;
    applyStimulus(1'b0, 32'h0, 32'h0);

    #12;
    checkOutput("reset_ex_valid", 64'(ex_valid), 64'h0);
    checkOutput("reset_id_ready", 64'(id_ready), 64'h0);
    checkOutput("reset_ctrl", 64'(ctrlNow()), 64'h0);
    checkOutput("reset_rs_val", 64'(rs_val_2_ex), 64'h0);
    @(negedge clk);
    reset = 1'b1;

    wbWrite(5'd1, 32'h11);
    wbWrite(5'd2, 32'h22);
    wbWrite(5'd3, 32'h0000_1234);
    wbWrite(5'd0, 32'hDEAD);

    // Table of single-instruction decodes, one accept per cycle.
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, vecs[i].inst, 32'h100 + 32'(i * 4));
      @(negedge clk);
      checkOutput($sformatf("v%0d_ex_valid", i), 64'(ex_valid), 64'h1);
      checkOutput($sformatf("v%0d_opcode", i), 64'(opcode_2_ex), 64'(vecs[i].op));
      checkOutput($sformatf("v%0d_rs_val", i), 64'(rs_val_2_ex), 64'(vecs[i].rs_val));
      checkOutput($sformatf("v%0d_rt_val", i), 64'(rt_val_2_ex), 64'(vecs[i].rt_val));
      checkOutput($sformatf("v%0d_rd", i), 64'(rd_2_ex), 64'(vecs[i].rd));
      checkOutput($sformatf("v%0d_imm", i), 64'(imm_2_ex), 64'(vecs[i].imm));
      checkOutput($sformatf("v%0d_ctrl", i), 64'(ctrlNow()), 64'(vecs[i].ctrl));
      checkOutput($sformatf("v%0d_pc", i), 64'(pc_2_ex), 64'(32'h100 + 32'(i * 4)));
      checkOutput($sformatf("v%0d_pc4", i), 64'(pc4_2_ex), 64'(32'h104 + 32'(i * 4)));
    end
    applyStimulus(1'b0, 32'h0, 32'h0);
    @(negedge clk);
    checkOutput("idle_bubble", 64'(ex_valid), 64'h0);

    // Load-use hazard: LDW r5 then add r6,r5,r1.
    applyStimulus(1'b1, encI(6'd12, 5'd1, 5'd5, 16'h0), 32'h200);
    @(negedge clk);
    applyStimulus(1'b1, encR(6'd0, 5'd5, 5'd1, 5'd6), 32'h204);
    #1 checkOutput("hz_id_ready", 64'(id_ready), 64'h0);
    @(negedge clk);
    checkOutput("hz_bubble", 64'(ex_valid), 64'h0);
    checkOutput("hz_ready_after", 64'(id_ready), 64'h1);
    @(negedge clk);
    checkOutput("hz_accept_valid", 64'(ex_valid), 64'h1);
    checkOutput("hz_accept_rd", 64'(rd_2_ex), 64'h6);
    checkOutput("hz_accept_pc", 64'(pc_2_ex), 64'h204);

    // Load to r0 never creates a hazard.
    applyStimulus(1'b1, encI(6'd12, 5'd1, 5'd0, 16'h0), 32'h300);
    @(negedge clk);
    applyStimulus(1'b1, encR(6'd0, 5'd0, 5'd1, 5'd6), 32'h304);
    #1 checkOutput("nohz_id_ready", 64'(id_ready), 64'h1);
    @(negedge clk);
    checkOutput("nohz_valid", 64'(ex_valid), 64'h1);
    checkOutput("nohz_pc", 64'(pc_2_ex), 64'h304);

    // Same-cycle WB write of r7 and read of r7.
    wb_we = 1'b1; wb_addr = 5'd7; wb_data = 32'hA5;
    applyStimulus(1'b1, encR(6'd0, 5'd7, 5'd0, 5'd8), 32'h400);
    @(negedge clk);
    wb_we = 1'b0;
`ifdef ID_BYPASS_EN
    checkOutput("bypass_rs_val", 64'(rs_val_2_ex), 64'hA5);
`else
    checkOutput("bypass_rs_val", 64'(rs_val_2_ex), 64'h0);
`endif
    @(negedge clk);
    checkOutput("r7_after_write", 64'(rs_val_2_ex), 64'hA5);

    // Stall holds the entry; flush during stall clears it.
    applyStimulus(1'b1, encR(6'd0, 5'd1, 5'd2, 5'd6), 32'h500);
    @(negedge clk);
    checkOutput("stall_pre_valid", 64'(ex_valid), 64'h1);
    ex_stall = 1'b1;
    applyStimulus(1'b1, encR(6'd10, 5'd2, 5'd3, 5'd9), 32'h504);
    for (int c = 0; c < 3; c++) begin
      #1 checkOutput($sformatf("stall%0d_id_ready", c), 64'(id_ready), 64'h0);
      @(negedge clk);
      checkOutput($sformatf("stall%0d_valid", c), 64'(ex_valid), 64'h1);
      checkOutput($sformatf("stall%0d_rd", c), 64'(rd_2_ex), 64'h6);
      checkOutput($sformatf("stall%0d_rs_val", c), 64'(rs_val_2_ex), 64'h11);
      checkOutput($sformatf("stall%0d_pc", c), 64'(pc_2_ex), 64'h500);
    end
    flush = 1'b1;
    @(negedge clk);
    checkOutput("stall_flush_valid", 64'(ex_valid), 64'h0);
    flush = 1'b0; ex_stall = 1'b0;
    applyStimulus(1'b0, 32'h0, 32'h0);

    // HALT accepted: stage parks until flush.
    applyStimulus(1'b1, {6'd17, 26'd0}, 32'h600);
    @(negedge clk);
    checkOutput("halt_flag", 64'(halt_2_ex), 64'h1);
    checkOutput("halt_valid", 64'(ex_valid), 64'h1);
    applyStimulus(1'b1, encR(6'd0, 5'd1, 5'd2, 5'd6), 32'h604);
    for (int c = 0; c < 10; c++) begin
      #1 checkOutput($sformatf("halted%0d_id_ready", c), 64'(id_ready), 64'h0);
      @(negedge clk);
      checkOutput($sformatf("halted%0d_valid", c), 64'(ex_valid), 64'h0);
    end
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    #1 checkOutput("unhalt_id_ready", 64'(id_ready), 64'h1);
    @(negedge clk);
    checkOutput("unhalt_valid", 64'(ex_valid), 64'h1);
    checkOutput("unhalt_pc", 64'(pc_2_ex), 64'h604);

    // HALT with flush in the same cycle is discarded.
    applyStimulus(1'b1, {6'd17, 26'd0}, 32'h700);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    applyStimulus(1'b0, 32'h0, 32'h0);
    #1;
    checkOutput("haltflush_halt", 64'(halt_2_ex), 64'h0);
    checkOutput("haltflush_valid", 64'(ex_valid), 64'h0);
    checkOutput("haltflush_id_ready", 64'(id_ready), 64'h1);
    @(negedge clk);
    checkOutput("haltflush_still_run", 64'(id_ready), 64'h1);

    // Reset in the middle of operation with a valid entry.
    applyStimulus(1'b1, encR(6'd0, 5'd1, 5'd2, 5'd6), 32'h800);
    @(negedge clk);
    checkOutput("midreset_pre_valid", 64'(ex_valid), 64'h1);
    reset = 1'b0;
    #1;
    checkOutput("midreset_valid", 64'(ex_valid), 64'h0);
    checkOutput("midreset_rs_val", 64'(rs_val_2_ex), 64'h0);
    checkOutput("midreset_rd", 64'(rd_2_ex), 64'h0);
    checkOutput("midreset_pc", 64'(pc_2_ex), 64'h0);
    checkOutput("midreset_ctrl", 64'(ctrlNow()), 64'h0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("postreset_valid", 64'(ex_valid), 64'h1);
    checkOutput("postreset_rs_val", 64'(rs_val_2_ex), 64'h0);
    checkOutput("postreset_rt_val", 64'(rt_val_2_ex), 64'h0);
    applyStimulus(1'b0, 32'h0, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/id_stage_p.md
Name: id_stage_p

Overview:
- Parametrised successor instruction-decode stage for the 5-stage pipeline.
- Decodes one 32-bit instruction per cycle and reads the register file with optional WB-to-ID bypass.
- Registers decoded fields and control into the ID/EX pipeline register, using a valid/stall/flush protocol.
- Detects load-use hazards and inserts bubbles; tracks HALT with a small state machine.

Parameters:
- D_SIZE, 32: register and datapath width in bits (≥16).
- NUM_REGS, 32: register count, power of two, 2..32.
- ADDR_W, $clog2(NUM_REGS): register address width (derived; do not override).

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- if_valid  in  1  inst/pc/pc4 valid from IF
- inst  in  32  instruction word
- pc_in  in  32  PC of inst
- pc4_in  in  32  PC+4 of inst
- id_ready  out  1  ID accepts inst this cycle
- wb_we  in  1  WB write enable
- wb_addr  in  ADDR_W  WB destination
- wb_data  in  D_SIZE  WB write data
- ex_stall  in  1  EX cannot accept; hold ID/EX register
- flush  in  1  discard ID contents (taken branch)
- ex_valid  out  1  ID/EX entry valid
- opcode_2_ex  out  6  opcode
- pc_2_ex, pc4_2_ex  out  32  registered PCs
- rs_val_2_ex, rt_val_2_ex  out  D_SIZE  operand values
- rd_2_ex  out  ADDR_W  destination register
- imm_2_ex  out  D_SIZE  sign-extended immediate
- branch_2_ex, mem_read_2_ex, mem_to_reg_2_ex, mem_write_2_ex, halt_2_ex  out  1 each  control

Behaviour:
- Reset (reset low, async): all outputs 0, all registers 0, state RUN.
- Fields: op=inst[31:26], rs=inst[25:21], rt=inst[20:16], rd=inst[15:11]; register indices truncated to ADDR_W bits.
- Immediate: inst[15:0] sign-extended to D_SIZE.
- R-type (op 0,2,4,6,8,10: add, sub, mul, or, and, xor):
  - Read rs and rt; dest = rd; imm = 0; mem_to_reg = 1.
- I-type ALU (op 1,3,5,7,9,11):
  - Read rs; rt_val = 0; dest = rt; imm used; mem_to_reg = 1.
- LDW (12): as I-type ALU, plus mem_read = 1.
- STW (13): read rs and rt (rt_val = store data); dest = 0; mem_write = 1; mem_to_reg = 0.
- BZ (14), JR (16): read rs; branch = 1; dest = 0.
- BEQ (15): read rs and rt; branch = 1; dest = 0.
- HALT (17): all fields 0; halt = 1.
- Any other opcode: NOP (all control 0, ex_valid = 1).
- Register file:
  - Write on clk when wb_we=1 and wb_addr≠0.
  - Register 0 always reads 0; writes to it are ignored.
- Hazard: hz = ex_valid & mem_read_2_ex & rd_2_ex≠0 & (rd_2_ex matches a used source of inst).
- id_ready = (state==RUN) & ~ex_stall & ~hz.
- Accept = if_valid & id_ready.
- ID/EX register update, in priority order:
  1. flush: ex_valid←0 (other fields don't care, cleared to 0).
  2. ex_stall: hold all.
  3. accept: load decode, ex_valid←1.
  4. otherwise: ex_valid←0 (bubble).
- Latency: 1 cycle from accept to ex_valid.
- Hazard bubble lasts exactly 1 cycle when ex_stall is low.
- FSM:
  - RUN→HALTED on accepting HALT without flush.
  - HALTED→RUN on flush.
  - HALTED holds otherwise; id_ready = 0 while HALTED.
  - Flush and HALT in the same cycle: HALT discarded, state stays RUN.

Optional Feature:
- Macro ID_BYPASS_EN.
- Defined: if wb_we & wb_addr≠0 & wb_addr equals a read index, that read returns wb_data in the same cycle (write-through).
- Undefined: reads return the pre-write register contents; software must separate a WB write and a dependent read by ≥1 cycle.

Test Plan:
- Reset low mid-operation with ex_valid=1 → all outputs 0 immediately; regs read 0 after release.
- WB writes r3=0x0000_1234; then addi r4,r3,0xFFFF accepted → rs_val=0x1234, imm=0xFFFF_FFFF, rd=4, mem_to_reg=1, ex_valid next cycle.
- LDW r5 in EX, then add r6,r5,r1 presented:
  - One bubble (ex_valid=0, id_ready=0) for 1 cycle.
  - The add is then accepted.
  - With rd=0 instead of r5, no bubble.
- Write r7=0xA5 and read r7 in the same cycle:
  - With ID_BYPASS_EN: rs_val=0xA5.
  - Without it: rs_val = old value 0.
- ex_stall=1 for 3 cycles with valid entry → outputs unchanged, id_ready=0; flush during stall → ex_valid=0 next cycle.
- HALT accepted → halt_2_ex=1, id_ready stays 0 for 10 cycles; flush → RUN, next inst accepted. HALT together with flush → no halt, id_ready=1.
